// File: rtl/sseg4_scan_ctrl.sv
// Four-digit seven-segment scan controller with a two-source display arbiter.
// Requests are only looked at once per frame, so the displayed value never tears mid-scan.
module sseg4_scan_ctrl #(
  parameter int DIV = 100000
) (
  input  logic        clk,
  input  logic        btnC,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [15:0] data_a,
  input  logic [15:0] data_b,
  input  logic        hex_dec_a,
  input  logic        hex_dec_b,
  input  logic        sign_a,
  input  logic        sign_b,
  output logic        ack_a,
  output logic        ack_b,
  output logic [15:0] data,
  output logic        hex_dec,
  output logic        sign,
  output logic [1:0]  digit_sel,
  output logic        frame_tick,
  output logic [1:0]  owner
);

  // state | meaning
  // SCAN  | scanning digits, arbitrating requests at each frame end
  // ACK_A | one-cycle capture acknowledge to source A
  // ACK_B | one-cycle capture acknowledge to source B
  typedef enum logic [1:0] {SCAN, ACK_A, ACK_B} state_t;

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  digit_sel_q, digit_sel_d;
  logic        frame_tick_q, frame_tick_d;
  logic [15:0] data_q, data_d;
  logic        hex_dec_q, hex_dec_d;
  logic        sign_q, sign_d;
  logic [1:0]  owner_q, owner_d;
  logic        last_grant_q, last_grant_d;  // 0 = A, 1 = B
  logic        tick;
  logic        frame_end;
  logic        grant_a;
  logic        grant_b;

  always_comb begin
    cnt_d        = cnt_q;
    digit_sel_d  = digit_sel_q;
    frame_tick_d = 1'b0;
    state_d      = state_q;
    data_d       = data_q;
    hex_dec_d    = hex_dec_q;
    sign_d       = sign_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    grant_a      = 1'b0;
    grant_b      = 1'b0;

    tick      = (cnt_q == CNT_MAX);
    frame_end = tick && (digit_sel_q == 2'd3);

    if (tick) begin
      cnt_d       = '0;
      digit_sel_d = digit_sel_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    frame_tick_d = frame_end;

    case (state_q)
      SCAN: begin
        if (frame_end) begin
          // On a tie the source that was not granted last time wins.
          grant_a = req_a && (!req_b || last_grant_q);
          grant_b = req_b && (!req_a || !last_grant_q);
          if (grant_a) begin
            state_d      = ACK_A;
            data_d       = data_a;
            hex_dec_d    = hex_dec_a;
            sign_d       = sign_a;
            owner_d      = 2'b01;
            last_grant_d = 1'b0;
          end else if (grant_b) begin
            state_d      = ACK_B;
            data_d       = data_b;
            hex_dec_d    = hex_dec_b;
            sign_d       = sign_b;
            owner_d      = 2'b10;
            last_grant_d = 1'b1;
          end
        end
      end
      ACK_A:   state_d = SCAN;
      ACK_B:   state_d = SCAN;
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (btnC) begin
      state_q      <= SCAN;
      cnt_q        <= '0;
      digit_sel_q  <= 2'd0;
      frame_tick_q <= 1'b0;
      data_q       <= 16'h0000;
      hex_dec_q    <= 1'b0;
      sign_q       <= 1'b0;
      owner_q      <= 2'b00;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      digit_sel_q  <= digit_sel_d;
      frame_tick_q <= frame_tick_d;
      data_q       <= data_d;
      hex_dec_q    <= hex_dec_d;
      sign_q       <= sign_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign ack_a      = (state_q == ACK_A);
  assign ack_b      = (state_q == ACK_B);
  assign data       = data_q;
  assign hex_dec    = hex_dec_q;
  assign sign       = sign_q;
  assign digit_sel  = digit_sel_q;
  assign frame_tick = frame_tick_q;
  assign owner      = owner_q;

endmodule

// File: tb/tb_sseg4_scan_ctrl.sv
// Bench for sseg4_scan_ctrl at DIV=4: directed steps, grant scoreboard, and a
// free-running scan model compared every cycle.
module tb_sseg4_scan_ctrl;

  logic        clk = 1'b0;
  logic        btnC;
  logic        req_a, req_b;
  logic [15:0] data_a, data_b;
  logic        hex_dec_a, hex_dec_b, sign_a, sign_b;
  logic        ack_a, ack_b;
  logic [15:0] data;
  logic        hex_dec, sign;
  logic [1:0]  digit_sel;
  logic        frame_tick;
  logic [1:0]  owner;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  src;
    logic [15:0] d;
    logic        hd;
    logic        sg;
  } exp_t;
  exp_t sb[$];

  int   m_cnt = 0;
  int   m_dsel = 0;
  logic m_ft = 1'b0;
  logic m_rst = 1'b1;

  logic [15:0] p_data = 16'h0000;
  logic [1:0]  p_owner = 2'b00;
  logic        p_hd = 1'b0;
  logic        p_sg = 1'b0;

  sseg4_scan_ctrl #(.DIV(4)) dut (
    .clk(clk), .btnC(btnC),
    .req_a(req_a), .req_b(req_b),
    .data_a(data_a), .data_b(data_b),
    .hex_dec_a(hex_dec_a), .hex_dec_b(hex_dec_b),
    .sign_a(sign_a), .sign_b(sign_b),
    .ack_a(ack_a), .ack_b(ack_b),
    .data(data), .hex_dec(hex_dec), .sign(sign),
    .digit_sel(digit_sel), .frame_tick(frame_tick), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output int n);
    logic got;
    got = 1'b0;
    n = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      step();
      n++;
      if (ack_a || ack_b) got = 1'b1;
    end
    check("ack_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic push(input logic [1:0] src, input logic [15:0] d, input logic hd, input logic sg);
    exp_t e;
    e.src = src; e.d = d; e.hd = hd; e.sg = sg;
    sb.push_back(e);
  endtask

  // Reference scan timing: DIV=4 clocks per digit, 4 digits per frame.
  always @(posedge clk) begin
    m_rst = btnC;
    if (btnC) begin
      m_cnt = 0; m_dsel = 0; m_ft = 1'b0;
    end else begin
      m_ft = (m_cnt == 3) && (m_dsel == 3);
      if (m_cnt == 3) begin
        m_cnt  = 0;
        m_dsel = (m_dsel + 1) % 4;
      end else begin
        m_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    check("digit_sel", {30'd0, digit_sel}, m_dsel[31:0]);
    check("frame_tick", {31'd0, frame_tick}, {31'd0, m_ft});
    check("ack_overlap", {31'd0, ack_a & ack_b}, 32'd0);
    if (m_rst) begin
      check("rst_data", {16'd0, data}, 32'd0);
      check("rst_owner", {30'd0, owner}, 32'd0);
      check("rst_ack", {30'd0, ack_b, ack_a}, 32'd0);
      check("rst_fmt", {30'd0, hex_dec, sign}, 32'd0);
    end else if (ack_a || ack_b) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", {30'd0, ack_b, ack_a}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_src", {30'd0, ack_b, ack_a}, {30'd0, e.src});
        check("grant_owner", {30'd0, owner}, {30'd0, e.src});
        check("grant_data", {16'd0, data}, {16'd0, e.d});
        check("grant_fmt", {30'd0, hex_dec, sign}, {30'd0, e.hd, e.sg});
        check("ack_at_frame", {31'd0, frame_tick}, 32'd1);
      end
    end else begin
      check("hold_data", {16'd0, data}, {16'd0, p_data});
      check("hold_owner", {30'd0, owner}, {30'd0, p_owner});
      check("hold_fmt", {30'd0, hex_dec, sign}, {30'd0, p_hd, p_sg});
    end
    p_data = data; p_owner = owner; p_hd = hex_dec; p_sg = sign;
  end

  initial begin
    int n;
    btnC = 1'b1;
    req_a = 1'b0; req_b = 1'b0;
    data_a = 16'h0000; data_b = 16'h0000;
    hex_dec_a = 1'b0; hex_dec_b = 1'b0; sign_a = 1'b0; sign_b = 1'b0;
    repeat (3) step();
    check("reset_dsel", {30'd0, digit_sel}, 32'd0);
    check("reset_data", {16'd0, data}, 32'd0);
    check("reset_owner", {30'd0, owner}, 32'd0);
    btnC = 1'b0;

    // Idle scan: two full frames with no requests.
    repeat (32) step();

    // Single request from A.
    data_a = 16'h007F; hex_dec_a = 1'b0; sign_a = 1'b0; req_a = 1'b1;
    push(2'b01, 16'h007F, 1'b0, 1'b0);
    wait_ack(n);
    req_a = 1'b0;
    step();
    check("ack_a_one_cycle", {31'd0, ack_a}, 32'd0);

    // Fresh reset held several cycles, then a sustained tie: A, B, A, B.
    btnC = 1'b1;
    repeat (4) step();
    btnC = 1'b0;
    data_a = 16'h1234; hex_dec_a = 1'b1; sign_a = 1'b0;
    data_b = 16'hABCD; hex_dec_b = 1'b1; sign_b = 1'b1;
    req_a = 1'b1; req_b = 1'b1;
    push(2'b01, 16'h1234, 1'b1, 1'b0);
    push(2'b10, 16'hABCD, 1'b1, 1'b1);
    push(2'b01, 16'h1234, 1'b1, 1'b0);
    push(2'b10, 16'hABCD, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_ack(n);
      if (i == 2) req_a = 1'b0;
    end
    req_b = 1'b0;

    // Mid-frame pulse on B that drops before frame end must be ignored.
    n = 0;
    for (int i = 0; i < 40 && !frame_tick; i++) step();
    check("align_frame", {31'd0, frame_tick}, 32'd1);
    repeat (5) step();
    data_b = 16'h5555; req_b = 1'b1;
    repeat (3) step();
    req_b = 1'b0;
    repeat (24) step();
    check("pulse_ignored_data", {16'd0, data}, {16'd0, 16'hABCD});

    // Grant A, then change data_a mid-frame: display must hold.
    data_a = 16'h0A0A; hex_dec_a = 1'b0; sign_a = 1'b1; req_a = 1'b1;
    push(2'b01, 16'h0A0A, 1'b0, 1'b1);
    wait_ack(n);
    req_a = 1'b0;
    repeat (4) step();
    data_a = 16'hFFFF;
    repeat (20) step();
    check("no_tear_data", {16'd0, data}, {16'd0, 16'h0A0A});
    req_a = 1'b1;
    push(2'b01, 16'hFFFF, 1'b0, 1'b1);
    wait_ack(n);
    req_a = 1'b0;

    // Reset during ACK_A with req_a still high.
    data_a = 16'h2222; hex_dec_a = 1'b1; sign_a = 1'b1; req_a = 1'b1;
    push(2'b01, 16'h2222, 1'b1, 1'b1);
    wait_ack(n);
    btnC = 1'b1;
    step();
    check("abort_ack_a", {31'd0, ack_a}, 32'd0);
    check("abort_data", {16'd0, data}, 32'd0);
    check("abort_owner", {30'd0, owner}, 32'd0);
    check("abort_fmt", {30'd0, hex_dec, sign}, 32'd0);
    repeat (2) step();
    btnC = 1'b0;
    push(2'b01, 16'h2222, 1'b1, 1'b1);
    wait_ack(n);
    check("post_reset_latency", n[31:0], 32'd16);
    req_a = 1'b0;

    repeat (20) step();
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sseg4_scan_ctrl.md
SSEG4_SCAN_CTRL -- requirements
Module: sseg4_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 100000, meaning clocks per digit slot (legal range DIV >= 2).
REQ-002 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-003 SHALL have port btnC  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports req_a, req_b  input  1  display-update requests from sources A and B.
REQ-005 SHALL have ports data_a, data_b  input  16  4-digit values offered by A and B.
REQ-006 SHALL have ports hex_dec_a, hex_dec_b, sign_a, sign_b  input  1  per-source format flags.
REQ-007 SHALL have ports ack_a, ack_b  output  1  one-cycle capture acknowledges.
REQ-008 SHALL have ports data  output  16, hex_dec  output  1, sign  output  1, which drive the seven-segment decoder.
REQ-009 SHALL have port digit_sel  output  2  active digit index for the decoder.
REQ-010 SHALL have port frame_tick  output  1  one-cycle pulse at each frame end.
REQ-011 SHALL have port owner  output  2  source of the displayed value: 00 none, 01 A, 10 B.

Function
REQ-012 SHALL run prescaler cnt over 0..DIV-1; tick is true when cnt==DIV-1, and cnt wraps to 0 on that edge.
REQ-013 SHALL increment digit_sel on every tick, wrapping 3->0; digit_sel is a registered output.
REQ-014 SHALL define frame_end = tick AND digit_sel==3; a frame is 4*DIV clocks.
REQ-015 SHALL assert frame_tick (registered) in the cycle after frame_end, for exactly one cycle.
REQ-016 SHALL implement FSM states SCAN, ACK_A, ACK_B; the prescaler and digit scan never stall in any state.
REQ-017 SCAN: at frame_end with only req_a high -> ACK_A; with only req_b high -> ACK_B; with neither high -> stay in SCAN.
REQ-018 SCAN with both requests high at frame_end SHALL grant the source other than last_grant (round robin); last_grant resets to B, so A wins the first tie.
REQ-019 On the SCAN->ACK_x edge SHALL load data_x, hex_dec_x and sign_x into the output registers, set owner to x and set last_grant to x.
REQ-020 ACK_x SHALL assert ack_x for exactly one cycle, then return to SCAN; ack_a and ack_b are never high together.
REQ-021 Outputs data, hex_dec and sign SHALL change only on a grant edge and hold between grants, so no mid-frame tearing occurs.
REQ-022 SHALL ignore requests outside frame_end; a requester holds req and data stable until it sees ack.
REQ-023 A req still high in the ack cycle SHALL be treated as a new request at the next frame_end.
REQ-024 Data and request changes between frame_ends SHALL have no effect on the outputs.
REQ-025 frame_end cannot fall in an ACK state (DIV >= 2); no back-to-back grants occur.

Reset
REQ-026 When btnC is high at a clock edge, on that edge the block SHALL set: cnt=0, digit_sel=0, data=16'h0000, hex_dec=0, sign=0, ack_a=ack_b=0, frame_tick=0, owner=00, last_grant=B, state=SCAN.
REQ-027 Reset during an ACK state SHALL abort it, with no ack pulse after reset; a still-pending req is served at the first frame_end after reset.
REQ-028 Reset held high for several cycles SHALL hold all of these values; the first frame_end after release comes 4*DIV clocks after release.

Verification (DIV=4, frame=16 clocks)
REQ-029 Reset then idle: digit_sel sequence 0,1,2,3 with 4 clocks per value; frame_tick every 16 clocks; data=0000; owner=00; no ack.
REQ-030 req_a=1, data_a=16'h007F, hex_dec_a=0, sign_a=0 -> ack_a one cycle after the first frame_end; data=007F and owner=01 in that same cycle; A then drops req.
REQ-031 req_a and req_b held high, data_a=1234, data_b=ABCD -> grants alternate A,B,A,... one per frame; data alternates 1234/ABCD; acks never overlap.
REQ-032 req_b pulsed high mid-frame and dropped before frame_end -> no ack_b; outputs unchanged.
REQ-033 btnC asserted in the ACK_A cycle with req_a still high -> no ack pulse after reset; all outputs at reset values; ack_a at the first frame_end after release.
REQ-034 data_a changed mid-frame after its grant -> displayed data unchanged until the next granted frame_end.
